// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Sequential instruction fetcher feeding a decode stage through a 2-entry
//   {pc, instruction} buffer. It issues word-aligned reads to instruction
//   memory with a req/ack handshake. It also handles branch redirects: when a
//   redirect hits while a read is still outstanding, that read has to be seen
//   through to completion so the bus protocol stays intact. The FSM enters
//   DROP until the stale read returns, and its data is thrown away.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     read request (held until imem_ack once raised)
//   imem_addr    read address, word aligned
//   imem_ack     completes a transfer when sampled high together with req
//   imem_rdata   instruction word, valid in the completing cycle
//   inst_valid   buffer head holds a valid instruction
//   inst         instruction at the buffer head
//   inst_pc      address of inst
//   inst_ready   decode accepts the head (pop) when high with inst_valid
//   redirect     flush the buffer and continue fetching at redirect_pc
//   redirect_pc  new fetch target, low two bits ignored
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int DEPTH = 2;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] drop_addr_reg, drop_addr_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;

    // Buffer storage, one {pc, instruction} pair per slot.
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic        push;
    logic        pop;
    logic        complete;
    logic        aligned_unused;

    // The low bits of redirect_pc are deliberately discarded.
    assign aligned_unused = ^redirect_pc[1:0];

    // -----------------------------------------------------------------------
    // Decode-side view: always the oldest entry.
    // -----------------------------------------------------------------------
    assign inst_valid = (count_reg != 2'd0);
    assign inst       = inst_mem[rd_ptr_reg];
    assign inst_pc    = pc_mem[rd_ptr_reg];

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        drop_addr_next = drop_addr_reg;
        count_next     = count_reg;
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        push           = 1'b0;
        pop            = 1'b0;
        imem_req       = 1'b0;
        imem_addr      = fetch_pc_reg;

        case (state_reg)
            FETCH: begin
                // A request can only be raised with a free slot. Nothing but
                // a push can fill the buffer, and a push needs this very
                // request to complete, so once raised the request stays up
                // (and fetch_pc stays put) until the ack. rst_n is folded in
                // so the request drops immediately on an asynchronous reset.
                imem_req  = rst_n && (count_reg != 2'd2);
                imem_addr = fetch_pc_reg;
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_reg;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = fetch_pc_reg;
            end
        endcase

        complete = imem_req && imem_ack;

        if (redirect) begin
            // Redirect beats push and pop: the buffer is flushed outright.
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            count_next    = 2'd0;
            rd_ptr_next   = 1'b0;
            wr_ptr_next   = 1'b0;
            if (state_reg == FETCH) begin
                if (imem_req && !imem_ack) begin
                    // Read still in flight: remember where it went so the
                    // address stays stable until the memory answers.
                    drop_addr_next = fetch_pc_reg;
                    state_next     = DROP;
                end
            end else if (imem_ack) begin
                // Stale read finishing on the same edge as a new redirect.
                state_next = FETCH;
            end
        end else if (state_reg == DROP) begin
            if (imem_ack) begin
                state_next = FETCH;
            end
        end else begin
            push = complete;
            pop  = inst_valid && inst_ready;
            if (push) begin
                wr_ptr_next   = ~wr_ptr_reg;
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FETCH;
            fetch_pc_reg  <= RESET_PC;
            drop_addr_reg <= 32'd0;
            count_reg     <= 2'd0;
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            drop_addr_reg <= drop_addr_next;
            count_reg     <= count_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Buffer slots. They are cleared on reset so inst/inst_pc read as zero
    // while the unit is held in reset.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pc_mem[gi]   <= 32'd0;
                    inst_mem[gi] <= 32'd0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    pc_mem[gi]   <= fetch_pc_reg;
                    inst_mem[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed scenarios (stream, backpressure, redirects, wrap, mid-run reset)
// followed by a randomized run checked against a queue-based model of the
// fetch unit's behaviour. Inputs are driven and outputs sampled just after
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] TAG = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return just after the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: req=%b valid=%b, required req=0 valid=0", imem_req, inst_valid);
        end
        n_checks++;
        if (inst !== 32'd0 || inst_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: inst=%h pc=%h, required 0/0", inst, inst_pc);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a = 32'(4 * k);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                n_fail++;
                $display("FAIL stream_req[%0d]: req=%b addr=%h, required 1/%h", k, imem_req, imem_addr, a);
            end
            if (k > 0) begin
                n_checks++;
                if (inst_valid !== 1'b1 || inst_pc !== a - 32'd4 || inst !== ((a - 32'd4) ^ TAG)) begin
                    n_fail++;
                    $display("FAIL stream_inst[%0d]: valid=%b pc=%h inst=%h, required 1/%h/%h",
                             k, inst_valid, inst_pc, inst, a - 32'd4, (a - 32'd4) ^ TAG);
                end else begin
                    $display("stream: pc=%h inst=%h", inst_pc, inst);
                end
            end
            imem_rdata = a ^ TAG;
            tick();
        end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_backpressure();
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0 ^ TAG;
        tick();
        imem_rdata = 32'h4 ^ TAG;
        tick();
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_full: req=%b valid=%b pc=%h, required 0/1/0", imem_req, inst_valid, inst_pc);
        end
        tick();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: req=%b, required 0", imem_req);
        end
        inst_ready = 1'b1;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b1 || inst_pc !== 32'h4
            || inst !== (32'h4 ^ TAG)) begin
            n_fail++;
            $display("FAIL bp_pop1: req=%b addr=%h valid=%b pc=%h inst=%h, required 1/8/1/4/%h",
                     imem_req, imem_addr, inst_valid, inst_pc, inst, 32'h4 ^ TAG);
        end else begin
            $display("backpressure: pc=%h inst=%h", inst_pc, inst);
        end
        imem_ack = 1'b0;
        tick();
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL bp_pop2: valid=%b req=%b addr=%h, required 0/1/8", inst_valid, imem_req, imem_addr);
        end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_redirect_outstanding();
        do_reset();
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        imem_rdata = 32'h0 ^ TAG;
        tick();
        imem_rdata = 32'h4 ^ TAG;
        tick();
        n_checks++;
        if (imem_addr !== 32'h8 || inst_pc !== 32'h4 || inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_pre: addr=%h pc=%h valid=%b, required 8/4/1", imem_addr, inst_pc, inst_valid);
        end
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_drop[%0d]: req=%b addr=%h valid=%b, required 1/8/0",
                         k, imem_req, imem_addr, inst_valid);
            end
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_after: req=%b addr=%h valid=%b, required 1/100/0", imem_req, imem_addr, inst_valid);
        end
        imem_ack = 1'b0;
        tick();
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_stale: valid=%b inst=%h, required valid 0", inst_valid, inst);
        end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_simultaneous();
        do_reset();
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        imem_rdata = 32'h0 ^ TAG;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        imem_rdata  = 32'h4 ^ TAG;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL simul: valid=%b req=%b addr=%h, required 0/1/100", inst_valid, imem_req, imem_addr);
        end
        tick();
        n_checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL simul_after: valid=%b addr=%h, required 0/100", inst_valid, imem_addr);
        end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_wrap();
        do_reset();
        imem_ack    = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        imem_rdata  = 32'h1234_5678;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_top: req=%b addr=%h valid=%b, required 1/fffffffc/0", imem_req, imem_addr, inst_valid);
        end
        imem_rdata = 32'hFFFF_FFFC ^ TAG;
        tick();
        n_checks++;
        if (imem_addr !== 32'h0 || inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC
            || inst !== (32'hFFFF_FFFC ^ TAG)) begin
            n_fail++;
            $display("FAIL wrap_zero: addr=%h valid=%b pc=%h inst=%h, required 0/1/fffffffc/%h",
                     imem_addr, inst_valid, inst_pc, inst, 32'hFFFF_FFFC ^ TAG);
        end else begin
            $display("wrap: pc=%h inst=%h", inst_pc, inst);
        end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid();
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0 ^ TAG;
        tick();
        imem_rdata = 32'h4 ^ TAG;
        tick();
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_full: req=%b valid=%b, required 0/1", imem_req, inst_valid);
        end
        // Free one slot so a request goes out, then leave it unanswered.
        inst_ready = 1'b1;
        imem_ack   = 1'b0;
        tick();
        inst_ready = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pending: req=%b addr=%h valid=%b, required 1/8/1", imem_req, imem_addr, inst_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: req=%b valid=%b inst=%h pc=%h, required 0/0/0/0",
                     imem_req, inst_valid, inst, inst_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_release: req=%b addr=%h, required 1/0", imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0 ^ TAG;
        tick();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== TAG || imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL rstmid_first: valid=%b pc=%h inst=%h addr=%h, required 1/0/%h/4",
                     inst_valid, inst_pc, inst, imem_addr, TAG);
        end
        idle_inputs();
    endtask

    // -----------------------------------------------------------------------
    // Randomized run against a behavioural model: a queue holds what decode
    // should see; a flag records an abandoned read that must still finish.
    // -----------------------------------------------------------------------
    task automatic test_random();
        logic [63:0] mq[$];
        logic [31:0] m_fetch_pc;
        logic        m_dropping;
        logic [31:0] m_drop_addr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        int          pops;
        do_reset();
        mq.delete();
        m_fetch_pc  = 32'h0;
        m_dropping  = 1'b0;
        m_drop_addr = 32'h0;
        pops        = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            exp_req   = m_dropping ? 1'b1 : (mq.size() < 2);
            exp_addr  = m_dropping ? m_drop_addr : m_fetch_pc;
            exp_valid = (mq.size() != 0);
            n_checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
                n_fail++;
                $display("FAIL rand_req[%0d]: req=%b addr=%h, required %b/%h", cyc, imem_req, imem_addr, exp_req, exp_addr);
            end
            n_checks++;
            if (inst_valid !== exp_valid || (exp_valid && {inst_pc, inst} !== mq[0])) begin
                n_fail++;
                $display("FAIL rand_inst[%0d]: valid=%b pc=%h inst=%h, required %b/%h", cyc, inst_valid, inst_pc, inst,
                         exp_valid, exp_valid ? mq[0] : 64'd0);
            end

            imem_ack   = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect   = ($urandom_range(0, 11) == 0);
            imem_rdata = $urandom;
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirect_pc = $urandom;

            if (!redirect && !m_dropping && exp_valid && inst_ready) begin
                pops++;
                $display("random: pop pc=%h inst=%h", mq[0][63:32], mq[0][31:0]);
            end

            if (redirect) begin
                if (!m_dropping && exp_req && !imem_ack) begin
                    m_dropping  = 1'b1;
                    m_drop_addr = m_fetch_pc;
                end else if (m_dropping && imem_ack) begin
                    m_dropping = 1'b0;
                end
                mq.delete();
                m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (m_dropping) begin
                if (imem_ack) m_dropping = 1'b0;
            end else begin
                if (exp_valid && inst_ready) void'(mq.pop_front());
                if (exp_req && imem_ack) begin
                    mq.push_back({m_fetch_pc, imem_rdata});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
            tick();
        end
        $display("random: %0d instructions delivered", pops);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
